ad9648_spi_decoder: RTL

- Passive decoder for the AD9648 3-wire SPI configuration bus. It sits directly downstream of the spy taps (ADC CS, Sclk, SDIO) of the Zmod Digitizer controller.
- Samples the bus in the SysClk100 domain and decodes instruction and data phases.
- Emits one 32-bit AXI-Stream record per transferred byte, through a small FIFO, to a capture sink (ILA or DMA).
- Never drives the bus.

---
 rtl/ad9648_spi_pkg.sv | 31 +++
 rtl/ad9648_spi_decoder_rec_fifo.sv | 42 ++++
 rtl/ad9648_spi_decoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ad9648_spi_pkg.sv
// ad9648_spi_pkg: record layout, decoder states and W encodings shared by the SPI decoder.
package ad9648_spi_pkg;
  localparam int REC_RW = 31;
  localparam int REC_W = 29;
  localparam int REC_W_W = 2;
  localparam int REC_ERR = 28;
  localparam int REC_IDX = 24;
  localparam int REC_IDX_W = 4;
  localparam int REC_ADDR = 8;
  localparam int REC_ADDR_W = 13;
  localparam int REC_DATA = 0;
  localparam int REC_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;
  localparam logic [1:0] W_1B = 2'b00;
  localparam logic [1:0] W_2B = 2'b01;
  localparam logic [1:0] W_3B = 2'b10;
  localparam logic [1:0] W_STREAM = 2'b11;
  function automatic logic [31:0] make_rec(input logic rw, input logic [1:0] w, input logic err,
                                           input logic [3:0] idx, input logic [12:0] addr,
                                           input logic [7:0] data);
    logic [31:0] r;
    r = '0;
    r[REC_RW] = rw;
    r[REC_W +: REC_W_W] = w;
    r[REC_ERR] = err;
    r[REC_IDX +: REC_IDX_W] = idx;
    r[REC_ADDR +: REC_ADDR_W] = addr;
    r[REC_DATA +: REC_DATA_W] = data;
    return r;
  endfunction
endpackage

// File: rtl/ad9648_spi_decoder_rec_fifo.sv
// rec_fifo: synchronous first-word-fall-through FIFO with a registered data output.
module rec_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ovf,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_data;
  logic [AW:0] r_wp, r_rp, w_wp_n, w_rp_n;
  logic w_full, w_rd, w_wr;
  assign w_full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_valid = r_wp != r_rp;
  assign w_rd = o_valid & i_ready;
  assign w_wr = i_push & (~w_full | w_rd);
  assign o_ovf = i_push & w_full & ~w_rd;
  assign w_wp_n = r_wp + {{AW{1'b0}}, w_wr};
  assign w_rp_n = r_rp + {{AW{1'b0}}, w_rd};
  assign o_data = r_data;
  // The next head is preloaded; bypass the incoming word when it becomes the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_data <= '0;
    end else begin
      r_wp <= w_wp_n;
      r_rp <= w_rp_n;
      r_data <= (w_wp_n == w_rp_n) ? '0 :
                (w_wr && r_wp == w_rp_n) ? i_data : r_mem[w_rp_n[AW-1:0]];
    end
  end
  always_ff @(posedge clk) if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/ad9648_spi_decoder.sv
// ad9648_spi_decoder: passive AD9648 3-wire SPI spy; emits one 32-bit record per transferred byte.
module ad9648_spi_decoder
  import ad9648_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        SysClk100,
  input  logic        SysReset,
  input  logic        aSpiCs_n,
  input  logic        aSpiSclk,
  input  logic        aSpiSdio,
  output logic        mRecTvalid,
  input  logic        mRecTready,
  output logic [31:0] mRecTdata,
  output logic        sBusy,
  output logic [15:0] sOvfCnt,
  output logic [15:0] sTxnCnt
);
  logic [SYNC_STAGES-1:0] r_cs_s, r_sclk_s, r_sdio_s;
  logic r_cs_q, r_sclk_q, r_fell, r_rw, r_push;
  logic [1:0] r_w, r_nb;
  logic [3:0] r_bitcnt, r_idx;
  logic [14:0] r_sr;
  logic [12:0] r_addr;
  logic [31:0] r_rec;
  state_t r_state;
  logic w_cs, w_sclk, w_sdio, w_cs_rise, w_cs_fall, w_sclk_rise, w_ovf;
  logic [7:0] w_byte, w_part;
  logic [31:0] w_err_rec;
  assign w_cs = r_cs_s[SYNC_STAGES-1];
  assign w_sclk = r_sclk_s[SYNC_STAGES-1];
  assign w_sdio = r_sdio_s[SYNC_STAGES-1];
  assign w_cs_rise = ~r_cs_q & w_cs;
  assign w_cs_fall = r_cs_q & ~w_cs;
  assign w_sclk_rise = ~r_sclk_q & w_sclk;
  assign w_byte = {r_sr[6:0], w_sdio};
  assign w_part = r_sr[7:0] << (3'd0 - r_bitcnt[2:0]);
  assign w_err_rec = (r_state == DATA) ? make_rec(r_rw, r_w, 1'b1, r_idx, r_addr, w_part)
                                       : make_rec(1'b0, 2'b00, 1'b1, r_idx, 13'd0, 8'd0);
  assign sBusy = r_state != IDLE;
  always_ff @(posedge SysClk100) begin
    if (SysReset) begin
      r_cs_s <= '1;
      r_sclk_s <= '0;
      r_sdio_s <= '0;
      r_cs_q <= 1'b1;
      r_sclk_q <= 1'b0;
    end else begin
      r_cs_s <= {r_cs_s[SYNC_STAGES-2:0], aSpiCs_n};
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], aSpiSclk};
      r_sdio_s <= {r_sdio_s[SYNC_STAGES-2:0], aSpiSdio};
      r_cs_q <= w_cs;
      r_sclk_q <= w_sclk;
    end
  end
  // A CS rise takes priority over any Sclk edge seen in the same cycle.
  always_ff @(posedge SysClk100) begin
    r_push <= 1'b0;
    if (SysReset) begin
      r_state <= IDLE;
      r_fell <= 1'b0;
      r_bitcnt <= '0;
      r_idx <= '0;
      r_nb <= '0;
      r_sr <= '0;
      r_rw <= 1'b0;
      r_w <= '0;
      r_addr <= '0;
      r_rec <= '0;
      r_push <= 1'b0;
      sTxnCnt <= '0;
      sOvfCnt <= '0;
    end else begin
      if (w_ovf && sOvfCnt != 16'hFFFF) sOvfCnt <= sOvfCnt + 16'd1;
      if (w_cs_rise) begin
        if (r_fell) sTxnCnt <= sTxnCnt + 16'd1;
        r_push <= r_state != IDLE && r_bitcnt != 4'd0;
        r_rec <= w_err_rec;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (w_cs_fall) begin
            r_fell <= 1'b1;
            r_bitcnt <= '0;
            r_idx <= '0;
            r_state <= INSTR;
          end
          INSTR: if (w_sclk_rise) begin
            r_sr <= {r_sr[13:0], w_sdio};
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd15) begin
              r_rw <= r_sr[14];
              r_w <= r_sr[13:12];
              r_addr <= {r_sr[11:0], w_sdio};
              r_bitcnt <= '0;
              r_nb <= '0;
              r_state <= DATA;
            end
          end
          DATA: if (w_sclk_rise) begin
            r_sr <= {r_sr[13:0], w_sdio};
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_push <= 1'b1;
              r_rec <= make_rec(r_rw, r_w, 1'b0, r_idx, r_addr, w_byte);
              r_idx <= r_idx + {3'd0, r_idx != 4'd15};
              r_addr <= r_addr - 13'd1;
              r_bitcnt <= '0;
              r_nb <= r_nb + 2'd1;
              if (r_w != W_STREAM && r_nb == r_w) r_state <= INSTR;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  rec_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk(SysClk100),
    .rst(SysReset),
    .i_push(r_push),
    .i_data(r_rec),
    .o_ovf(w_ovf),
    .o_valid(mRecTvalid),
    .i_ready(mRecTready),
    .o_data(mRecTdata)
  );
endmodule
